// File: rtl/rng_draw_unit.sv
// Seedable Galois LFSR draw unit: req/ack handshake returning values in [0, range_max]
// via rejection sampling, with a halved-candidate fallback after MAX_TRIES attempts.
`timescale 1ns/1ps

module rng_draw_unit #(
    parameter int unsigned     WIDTH        = 16,
    parameter int unsigned     OUT_W        = 14,
    parameter logic [WIDTH-1:0] TAPS        = 16'hB400,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1,
    parameter int unsigned     MAX_TRIES    = 16,
    parameter bit              FREE_RUN     = 1'b0
) (
    input  logic             CLK500Hz,
    input  logic             rstn,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    input  logic [OUT_W-1:0] range_max,
    input  logic             req,
    output logic             ready,
    output logic [OUT_W-1:0] random_number,
    output logic             valid,
    input  logic             ack
);

    localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [OUT_W-1:0] range_q, range_d;
    logic [OUT_W-1:0] mask, candidate;
    logic [OUT_W-1:0] rn_d;
    logic             valid_d, ready_d;

    // State and registered outputs
    always_ff @(posedge CLK500Hz) begin
        if (!rstn) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED_DEFAULT;
            tries_q       <= '0;
            range_q       <= '0;
            random_number <= '0;
            valid         <= 1'b0;
            ready         <= 1'b1;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            tries_q       <= tries_d;
            range_q       <= range_d;
            random_number <= rn_d;
            valid         <= valid_d;
            ready         <= ready_d;
        end
    end

    // Next state, LFSR update and draw decision
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        tries_d = tries_q;
        range_d = range_q;
        rn_d    = random_number;
        valid_d = valid;

        lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

        // Mask bit i is set when range_q has any bit at position >= i
        for (int i = 0; i < int'(OUT_W); i++) begin
            mask[i] = |(range_q >> i);
        end
        candidate = lfsr_step[OUT_W-1:0] & mask;

        if (FREE_RUN) begin
            lfsr_d = lfsr_step;
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    range_d = range_max;
                    tries_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (!seed_load) begin
                    lfsr_d  = lfsr_step;
                    tries_d = tries_q + TRY_W'(1);
                    if (candidate <= range_q) begin
                        rn_d    = candidate;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                        rn_d    = candidate >> 1;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Seed load wins over any step in the same cycle
        if (seed_load) begin
            lfsr_d = (seed_value == '0) ? SEED_DEFAULT : seed_value;
        end

        ready_d = (state_d == IDLE);
    end

endmodule
